// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a registered 2-entry
// skid buffer and valid/ready handshakes on both sides. A sideband tag rides
// along with each immediate.
// Optional feature macro: IMM_GEN_ILLEGAL_SRC_EN adds the out_err port, which
// flags entries whose immediate source select was the reserved code 3'b111.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_SRC_EN
  ,
  output logic             out_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } StateType;

  StateType state;
  StateType nextState;

  logic [31:0]      rawImm;
  logic             signExt;
  logic             illegalSrc;
  logic [5:0]       shamt;
  logic [XLEN-1:0]  decImm;
  logic             inFire;
  logic             outFire;
  logic             loadOut;
  logic             loadSkid;
  logic             outFromSkid;
  logic [XLEN-1:0]  skidImm;
  logic [TAG_W-1:0] skidTag;
  logic             unusedOpcode;

  // The opcode field never contributes to an immediate.
  assign unusedOpcode = ^in_instr[6:0];

  // Shift amounts are 5 bits on RV32 and 6 bits on RV64.
  assign shamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  // Extract the 32-bit immediate for the selected format; signExt says
  // whether bit 31 replicates upward when XLEN is wider than 32.
  always_comb begin
    rawImm     = '0;
    signExt    = 1'b0;
    illegalSrc = 1'b0;
    case (in_imm_src)
      3'b000: begin
        rawImm  = {{20{in_instr[31]}}, in_instr[31:20]};
        signExt = 1'b1;
      end
      3'b001: begin
        rawImm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        signExt = 1'b1;
      end
      3'b010: begin
        rawImm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        signExt = 1'b1;
      end
      3'b011: begin
        rawImm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        signExt = 1'b1;
      end
      3'b100: begin
        rawImm  = {in_instr[31:12], 12'b0};
        signExt = 1'b1;
      end
      3'b101: rawImm = {27'b0, in_instr[19:15]};
      3'b110: rawImm = {26'b0, shamt};
      default: illegalSrc = 1'b1;
    endcase
  end

  assign decImm = signExt ? XLEN'($signed(rawImm)) : XLEN'(rawImm);

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign inFire    = in_valid & in_ready;
  assign outFire   = out_valid & out_ready;

  // Buffer occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= nextState;
  end

  // Next occupancy and which data register loads; flush overrides everything.
  always_comb begin
    nextState   = state;
    loadOut     = 1'b0;
    loadSkid    = 1'b0;
    outFromSkid = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            nextState = BUSY;
            loadOut   = 1'b1;
          end
        end
        BUSY: begin
          if (inFire && outFire) begin
            loadOut = 1'b1;
          end else if (inFire) begin
            nextState = FULL;
            loadSkid  = 1'b1;
          end else if (outFire) begin
            nextState = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            nextState   = BUSY;
            outFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  // Output register: loads fresh decode, or the skid entry when draining FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm <= '0;
      out_tag <= '0;
    end else if (outFromSkid) begin
      out_imm <= skidImm;
      out_tag <= skidTag;
    end else if (loadOut) begin
      out_imm <= decImm;
      out_tag <= in_tag;
    end
  end

  // Skid register: holds the second entry while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidImm <= '0;
      skidTag <= '0;
    end else if (loadSkid) begin
      skidImm <= decImm;
      skidTag <= in_tag;
    end
  end

`ifdef IMM_GEN_ILLEGAL_SRC_EN
  logic skidErr;

  // Illegal-source flag travels through the buffer alongside its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err <= 1'b0;
      skidErr <= 1'b0;
    end else begin
      if (outFromSkid)  out_err <= skidErr;
      else if (loadOut) out_err <= illegalSrc;
      if (loadSkid)     skidErr <= illegalSrc;
    end
  end
`else
  logic unusedIllegal;

  // Without the error port the reserved code just decodes to zero.
  assign unusedIllegal = illegalSrc;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=32 and XLEN=64.
// Optional feature macro: IMM_GEN_ILLEGAL_SRC_EN enables the out_err checks.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic [2:0]  inImmSrc;
  logic [31:0] inTag;
  logic        outValid;
  logic        outReady;
  logic [31:0] outImm;
  logic [31:0] outTag;

  logic        in64Valid;
  logic        in64Ready;
  logic [31:0] in64Instr;
  logic [2:0]  in64ImmSrc;
  logic [31:0] in64Tag;
  logic        out64Valid;
  logic        out64Ready;
  logic [63:0] out64Imm;
  logic [31:0] out64Tag;

`ifdef IMM_GEN_ILLEGAL_SRC_EN
  logic        outErr;
  logic        out64Err;
`endif

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_instr   (inInstr),
    .in_imm_src (inImmSrc),
    .in_tag     (inTag),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_imm    (outImm),
    .out_tag    (outTag)
`ifdef IMM_GEN_ILLEGAL_SRC_EN
    ,
    .out_err    (outErr)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk        (clk),
    .rst        (rst),
    .flush      (1'b0),
    .in_valid   (in64Valid),
    .in_ready   (in64Ready),
    .in_instr   (in64Instr),
    .in_imm_src (in64ImmSrc),
    .in_tag     (in64Tag),
    .out_valid  (out64Valid),
    .out_ready  (out64Ready),
    .out_imm    (out64Imm),
    .out_tag    (out64Tag)
`ifdef IMM_GEN_ILLEGAL_SRC_EN
    ,
    .out_err    (out64Err)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the 32-bit instance's producer side.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [2:0] src, input logic [31:0] tag);
    inValid  = valid;
    inInstr  = instr;
    inImmSrc = src;
    inTag    = tag;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  logic [31:0] vecInstr [8];
  logic [2:0]  vecSrc   [8];
  logic [31:0] vecImm   [8];

  // Directed sequence covering decode, back-pressure, flush and reset.
  initial begin
    vecInstr[0] = 32'hFFF00093; vecSrc[0] = 3'b000; vecImm[0] = 32'hFFFFFFFF;
    vecInstr[1] = 32'hFE112E23; vecSrc[1] = 3'b001; vecImm[1] = 32'hFFFFFFFC;
    vecInstr[2] = 32'h123450B7; vecSrc[2] = 3'b100; vecImm[2] = 32'h12345000;
    vecInstr[3] = 32'hFE000EE3; vecSrc[3] = 3'b010; vecImm[3] = 32'hFFFFFFFC;
    vecInstr[4] = 32'h0080006F; vecSrc[4] = 3'b011; vecImm[4] = 32'h00000008;
    vecInstr[5] = 32'hFFFFD073; vecSrc[5] = 3'b101; vecImm[5] = 32'h0000001F;
    vecInstr[6] = 32'h03F0D093; vecSrc[6] = 3'b110; vecImm[6] = 32'h0000001F;
    vecInstr[7] = 32'hFFFFFFFF; vecSrc[7] = 3'b111; vecImm[7] = 32'h00000000;

    rst = 1'b1;
    flush = 1'b0;
    outReady = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    in64Valid = 1'b0; in64Instr = 32'h0; in64ImmSrc = 3'b000; in64Tag = 32'h0;
    out64Ready = 1'b1;

    #2;
    checkOutput("rst_out_valid", {63'b0, outValid}, 64'd0);
    checkOutput("rst_out_imm", {32'b0, outImm}, 64'd0);
    checkOutput("rst_out_tag", {32'b0, outTag}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, inReady}, 64'd1);
    checkOutput("rst64_out_imm", out64Imm, 64'd0);
    tick();
    rst = 1'b0;

    $display("[TB] decode vectors, out_ready held high");
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecInstr[i], vecSrc[i], 32'h100 + i);
      tick();
      checkOutput($sformatf("dec%0d_valid", i), {63'b0, outValid}, 64'd1);
      checkOutput($sformatf("dec%0d_imm", i), {32'b0, outImm}, {32'b0, vecImm[i]});
      checkOutput($sformatf("dec%0d_tag", i), {32'b0, outTag}, 64'h100 + i);
`ifdef IMM_GEN_ILLEGAL_SRC_EN
      checkOutput($sformatf("dec%0d_err", i), {63'b0, outErr}, (i == 7) ? 64'd1 : 64'd0);
`endif
    end
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
    checkOutput("dec_idle_valid", {63'b0, outValid}, 64'd0);

`ifdef IMM_GEN_ILLEGAL_SRC_EN
    $display("[TB] illegal source followed by a legal entry");
    applyStimulus(1'b1, 32'hFFFFFFFF, 3'b111, 32'h7);
    tick();
    checkOutput("err_flag", {63'b0, outErr}, 64'd1);
    checkOutput("err_imm", {32'b0, outImm}, 64'd0);
    applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'h8);
    tick();
    checkOutput("err_clear", {63'b0, outErr}, 64'd0);
    checkOutput("err_next_imm", {32'b0, outImm}, 64'hFFFFFFFF);
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
`endif

    $display("[TB] back-pressure fills the skid buffer");
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 3'b000, 32'd1);
    tick();
    checkOutput("bp_tag1_ready", {63'b0, inReady}, 64'd1);
    checkOutput("bp_tag1_out", {32'b0, outTag}, 64'd1);
    applyStimulus(1'b1, 32'h00200093, 3'b000, 32'd2);
    tick();
    checkOutput("bp_full_ready", {63'b0, inReady}, 64'd0);
    checkOutput("bp_full_out", {32'b0, outTag}, 64'd1);
    applyStimulus(1'b1, 32'h00300093, 3'b000, 32'd3);
    tick();
    checkOutput("bp_hold_ready", {63'b0, inReady}, 64'd0);
    checkOutput("bp_hold_out", {32'b0, outTag}, 64'd1);
    outReady = 1'b1;
    tick();
    checkOutput("bp_drain_tag2", {32'b0, outTag}, 64'd2);
    checkOutput("bp_drain_imm2", {32'b0, outImm}, 64'd2);
    checkOutput("bp_drain_ready", {63'b0, inReady}, 64'd1);
    tick();
    checkOutput("bp_drain_tag3", {32'b0, outTag}, 64'd3);
    checkOutput("bp_drain_valid3", {63'b0, outValid}, 64'd1);
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
    checkOutput("bp_empty", {63'b0, outValid}, 64'd0);

    $display("[TB] flush while full and while busy");
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h02100093, 3'b000, 32'h21);
    tick();
    applyStimulus(1'b1, 32'h02200093, 3'b000, 32'h22);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 32'h02300093, 3'b000, 32'h23);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    checkOutput("flush_full_valid", {63'b0, outValid}, 64'd0);
    checkOutput("flush_full_ready", {63'b0, inReady}, 64'd1);
    applyStimulus(1'b1, 32'h03100093, 3'b000, 32'h31);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 32'h03200093, 3'b000, 32'h32);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    outReady = 1'b1;
    checkOutput("flush_busy_valid", {63'b0, outValid}, 64'd0);
    tick();
    checkOutput("flush_no_ghost", {63'b0, outValid}, 64'd0);
    applyStimulus(1'b1, 32'h03300093, 3'b000, 32'h33);
    tick();
    checkOutput("flush_next_tag", {32'b0, outTag}, 64'h33);
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
    checkOutput("flush_next_drained", {63'b0, outValid}, 64'd0);

    $display("[TB] asynchronous reset while full");
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h04100093, 3'b000, 32'h41);
    tick();
    applyStimulus(1'b1, 32'h04200093, 3'b000, 32'h42);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", {63'b0, outValid}, 64'd0);
    checkOutput("arst_imm", {32'b0, outImm}, 64'd0);
    checkOutput("arst_tag", {32'b0, outTag}, 64'd0);
    checkOutput("arst_ready", {63'b0, inReady}, 64'd1);
    applyStimulus(1'b1, 32'h04300093, 3'b000, 32'h43);
    tick();
    checkOutput("arst_ignore_input", {63'b0, outValid}, 64'd0);
    rst = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b1, 32'h04400093, 3'b000, 32'h44);
    tick();
    checkOutput("arst_after_tag", {32'b0, outTag}, 64'h44);
    checkOutput("arst_after_imm", {32'b0, outImm}, 64'h44);
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
    checkOutput("arst_after_drain", {63'b0, outValid}, 64'd0);

    $display("[TB] XLEN=64 instance");
    in64Valid = 1'b1; in64Instr = 32'h800000B7; in64ImmSrc = 3'b100; in64Tag = 32'h5;
    tick();
    checkOutput("x64_u_imm", out64Imm, 64'hFFFFFFFF80000000);
    checkOutput("x64_u_tag", {32'b0, out64Tag}, 64'h5);
    in64Instr = 32'h03F0D093; in64ImmSrc = 3'b110; in64Tag = 32'h6;
    tick();
    checkOutput("x64_sh_imm", out64Imm, 64'h000000000000003F);
    in64Instr = 32'hFFF00093; in64ImmSrc = 3'b000; in64Tag = 32'h7;
    tick();
    checkOutput("x64_i_imm", out64Imm, 64'hFFFFFFFFFFFFFFFF);
    in64Valid = 1'b0;
    tick();
    checkOutput("x64_idle", {63'b0, out64Valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
